// File: rtl/control_input_conditioner.sv
// control_input_conditioner: synchronise, debounce and edge-detect board inputs, with frame-latched copies
//
// Ports:
//   i_clk          pixel clock, all logic on the rising edge
//   i_rst_n        asynchronous active-low reset
//   i_raw          raw asynchronous inputs, active high
//   i_nf           one-cycle new-frame strobe
//   o_level        debounced level
//   o_rise         one-cycle pulse on an accepted 0->1 (and on auto-repeat when enabled)
//   o_fall         one-cycle pulse on an accepted 1->0
//   o_frame_level  o_level captured at the last i_nf
//   o_frame_press  any rise seen during the previous frame interval
//
// Optional feature: define CONDITIONER_AUTOREPEAT_EN to add REPEAT_DELAY / REPEAT_PERIOD
// and re-pulse o_rise while an input is held high.
module control_input_conditioner #(
  parameter int NUM_INPUTS      = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 742500
`ifdef CONDITIONER_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 37125000,
  parameter int REPEAT_PERIOD   = 7425000
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_INPUTS-1:0] i_raw,
  input  logic                  i_nf,
  output logic [NUM_INPUTS-1:0] o_level,
  output logic [NUM_INPUTS-1:0] o_rise,
  output logic [NUM_INPUTS-1:0] o_fall,
  output logic [NUM_INPUTS-1:0] o_frame_level,
  output logic [NUM_INPUTS-1:0] o_frame_press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
`ifdef CONDITIONER_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);
`endif
  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_e;
  logic [SYNC_STAGES-1:0][NUM_INPUTS-1:0] sync_q;
  logic [NUM_INPUTS-1:0] s, rise_d, fall_d;
  logic [NUM_INPUTS-1:0] level_q, rise_q, fall_q, frame_level_q, frame_press_q, sticky_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
  end
  assign s = sync_q[SYNC_STAGES-1];
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_in
    state_e st_q;
    logic [CW-1:0] cnt_q, cnt_inc;
    logic acc_hi, acc_lo;
    assign cnt_inc = (cnt_q == CMAX) ? cnt_q : cnt_q + CW'(1);
    assign acc_hi = st_q == WAIT_HI && s[i] && cnt_q == CMAX;
    assign acc_lo = st_q == WAIT_LO && !s[i] && cnt_q == CMAX;
    assign fall_d[i] = acc_lo;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        st_q  <= STABLE_LO;
        cnt_q <= '0;
      end else begin
        case (st_q)
          STABLE_LO: begin
            st_q  <= s[i] ? WAIT_HI : STABLE_LO;
            cnt_q <= s[i] ? CW'(1) : '0;
          end
          WAIT_HI: begin
            st_q  <= !s[i] ? STABLE_LO : acc_hi ? STABLE_HI : WAIT_HI;
            cnt_q <= (!s[i] || acc_hi) ? '0 : cnt_inc;
          end
          STABLE_HI: begin
            st_q  <= !s[i] ? WAIT_LO : STABLE_HI;
            cnt_q <= !s[i] ? CW'(1) : '0;
          end
          WAIT_LO: begin
            st_q  <= s[i] ? STABLE_HI : acc_lo ? STABLE_LO : WAIT_LO;
            cnt_q <= (s[i] || acc_lo) ? '0 : cnt_inc;
          end
        endcase
      end
    end
`ifdef CONDITIONER_AUTOREPEAT_EN
    logic [RW-1:0] rpt_q;
    logic first_q, hold_hi, enter_hi, rpt_fire;
    assign hold_hi  = st_q == STABLE_HI && s[i];
    assign enter_hi = acc_hi || (st_q == WAIT_LO && s[i]);
    assign rpt_fire = hold_hi && rpt_q == (first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD));
    assign rise_d[i] = acc_hi | rpt_fire;
    // rpt_q counts cycles since acceptance (or since the last repeat); first_q selects the initial delay
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        rpt_q   <= '0;
        first_q <= 1'b1;
      end else begin
        rpt_q   <= hold_hi ? (rpt_fire ? RW'(1) : rpt_q + RW'(1)) : enter_hi ? RW'(1) : '0;
        first_q <= hold_hi ? first_q & ~rpt_fire : 1'b1;
      end
    end
`else
    assign rise_d[i] = acc_hi;
`endif
  end
  // sticky tracks rises at the same edge they are issued, so a rise coincident with i_nf
  // lands only in the new o_frame_press and never carries into the next frame
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      level_q       <= '0;
      rise_q        <= '0;
      fall_q        <= '0;
      frame_level_q <= '0;
      frame_press_q <= '0;
      sticky_q      <= '0;
    end else begin
      level_q  <= (level_q | rise_d) & ~fall_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= i_nf ? '0 : sticky_q | rise_d;
      if (i_nf) begin
        frame_level_q <= level_q;
        frame_press_q <= sticky_q | rise_d;
      end
    end
  end
  assign o_level       = level_q;
  assign o_rise        = rise_q;
  assign o_fall        = fall_q;
  assign o_frame_level = frame_level_q;
  assign o_frame_press = frame_press_q;
endmodule

// File: doc/control_input_conditioner.md
Name: control_input_conditioner

Overview:
- Conditions asynchronous board inputs (paddle buttons, speed switches) before the Pong game logic in the 720p pixel-clock domain.
- Per input: multi-flop synchroniser, counter debouncer, registered rise/fall pulses.
- Also provides frame-latched copies, so game logic sampling on the new-frame strobe never misses a press that occurs between frames.

Parameters:
- NUM_INPUTS, 4: number of independent raw inputs conditioned.
- SYNC_STAGES, 2: synchroniser flop depth; legal range 2..4.
- DEBOUNCE_CYCLES, 742500: consecutive stable cycles required to accept a change (10 ms at 74.25 MHz); minimum 1.

Ports:
- i_clk  in  1  pixel clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_raw  in  NUM_INPUTS  raw asynchronous inputs, active high.
- i_nf  in  1  one-cycle new-frame strobe from the video timing generator.
- o_level  out  NUM_INPUTS  debounced level.
- o_rise  out  NUM_INPUTS  one-cycle pulse on accepted 0->1.
- o_fall  out  NUM_INPUTS  one-cycle pulse on accepted 1->0.
- o_frame_level  out  NUM_INPUTS  o_level captured at the last i_nf.
- o_frame_press  out  NUM_INPUTS  set if any rise occurred during the previous frame interval.

Behaviour:
- Interface (already decided): one clock, i_clk; reset i_rst_n is asynchronous and active-low.
- Reset (i_rst_n=0, any time, including mid-debounce):
  - all sync flops, counters, sticky bits and every output = 0;
  - every FSM = STABLE_LO.
- Synchroniser: i_raw[n] passes through SYNC_STAGES flops. s[n] is the last stage.
- Per-input FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
  - STABLE_LO: s=1 -> WAIT_HI, cnt=1; otherwise stay, cnt=0.
  - WAIT_HI: s=0 -> STABLE_LO, cnt=0 (bounce rejected). s=1 and cnt==DEBOUNCE_CYCLES -> STABLE_HI, o_level=1, o_rise=1 for one cycle. Otherwise cnt+1.
  - STABLE_HI / WAIT_LO: mirror of the above with polarity swapped; acceptance pulses o_fall.
- Counter:
  - width $clog2(DEBOUNCE_CYCLES+1), saturating, never wraps;
  - cleared on every state change.
- Latency:
  - raw edge sampled at edge k -> s changes at k+SYNC_STAGES;
  - o_level/o_rise change at edge k+SYNC_STAGES+DEBOUNCE_CYCLES, provided the input stays stable.
- Outputs are registered. o_rise and o_fall are mutually exclusive per input and never assert in consecutive cycles for the same input.
- Frame latch: sticky[n] sets on o_rise[n]. On an i_nf cycle:
  - o_frame_level <= o_level (the value before this edge's update);
  - o_frame_press <= sticky | rise_next, where rise_next is the rise being asserted at this same edge;
  - sticky <= 0.
  - A rise coincident with i_nf therefore appears in the new o_frame_press and is not double-counted.
- o_frame_* hold between i_nf strobes. Back-to-back i_nf strobes are legal.
- Power-up with an input held high: after reset release the input is debounced normally, and o_rise fires once at SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- Inputs are fully independent. Simultaneous events on different inputs are all reported in the same cycle.

Optional Feature:
- Macro: CONDITIONER_AUTOREPEAT_EN.
- Defined:
  - Adds parameters REPEAT_DELAY (default 37125000) and REPEAT_PERIOD (default 7425000).
  - While an input is STABLE_HI, o_rise re-pulses REPEAT_DELAY cycles after acceptance, then every REPEAT_PERIOD cycles.
  - Leaving STABLE_HI cancels repeating. Repeat pulses also set sticky.
- Undefined: no repeat logic or parameters; o_rise fires only on accepted transitions.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2, NUM_INPUTS=4):
1. Clean press: i_raw[0] 0->1 sampled at edge 10 and held -> o_level[0]=1 and o_rise[0] single pulse at edge 20; o_fall stays 0.
2. Bounce: i_raw[1] high for 5 cycles, low 2, high 20 -> o_rise[1] exactly once, 8 cycles after the final stable high reaches s.
3. Release: after test 1, i_raw[0] -> 0 held -> o_fall[0] pulse 10 cycles later, o_level[0]=0.
4. Frame latch: press/release i_raw[2] fully between two i_nf strobes -> next i_nf gives o_frame_press[2]=1, o_frame_level[2]=0; the following i_nf gives o_frame_press[2]=0.
5. Coincidence: o_rise[3] asserted at the same edge as i_nf -> o_frame_press[3]=1 after that edge; next frame with no press gives 0.
6. Reset mid-operation: assert i_rst_n=0 asynchronously mid-WAIT_HI with o_level=4'b0101 -> all outputs 0 immediately. After release with all i_raw held high, o_rise=4'b1111 once, 10 cycles after the first post-reset edge.
